// File: rtl/msk_pkg.sv
// Shared constants for the masked gadget pipeline controller: default latencies
// per gadget family and the in-flight counter width derivation.
package msk_pkg;

    localparam int MSK_SBOX_LAT = 4;
    localparam int MSK_AND_LAT  = 1;

    // Bits needed to count 0..value-1; call with LAT+1 to size the in-flight counter.
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/msk_pipe_ctrl_if.sv
// Handshake bundle between sequencer, randomness source, masked datapath and the
// pipeline controller. The flush wire exists only when MSK_PIPE_FLUSH_EN is defined.
interface msk_pipe_ctrl_if #(
    parameter int CNT_W = 3
);
    logic             in_valid;
    logic             in_ready;
    logic             rnd_valid;
    logic             rnd_ready;
    logic             pipe_en;
    logic             pipe_in_valid;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic [CNT_W-1:0] inflight;
`ifdef MSK_PIPE_FLUSH_EN
    logic             flush;

    modport master (
        output in_valid, rnd_valid, out_ready, flush,
        input  in_ready, rnd_ready, pipe_en, pipe_in_valid, out_valid, busy, inflight
    );

    modport slave (
        input  in_valid, rnd_valid, out_ready, flush,
        output in_ready, rnd_ready, pipe_en, pipe_in_valid, out_valid, busy, inflight
    );
`else
    modport master (
        output in_valid, rnd_valid, out_ready,
        input  in_ready, rnd_ready, pipe_en, pipe_in_valid, out_valid, busy, inflight
    );

    modport slave (
        input  in_valid, rnd_valid, out_ready,
        output in_ready, rnd_ready, pipe_en, pipe_in_valid, out_valid, busy, inflight
    );
`endif
endinterface

// File: rtl/msk_vld_shreg.sv
// Per-stage occupancy shift register: one valid bit per gadget register stage,
// advancing only when the pipeline enable is high; clr empties it synchronously.
module msk_vld_shreg #(
    parameter int LAT = 4
) (
    input  logic           clk,
    input  logic           nrst,
    input  logic           en,
    input  logic           clr,
    input  logic           din,
    output logic [LAT-1:0] vld
);

    generate
        if (LAT == 1) begin : g_single
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst)
                    vld <= '0;
                else if (clr)
                    vld <= '0;
                else if (en)
                    vld <= din;
            end
        end else begin : g_multi
            always_ff @(posedge clk or negedge nrst) begin
                if (!nrst)
                    vld <= '0;
                else if (clr)
                    vld <= '0;
                else if (en)
                    vld <= {vld[LAT-2:0], din};
            end
        end
    endgenerate

endmodule

// File: rtl/msk_pipe_ctrl.sv
// Flow controller for a fixed-latency masked gadget pipeline: admits operations only
// with fresh randomness, freezes on output backpressure. Optional flush: MSK_PIPE_FLUSH_EN.
module msk_pipe_ctrl
    import msk_pkg::*;
#(
    parameter int LAT   = MSK_SBOX_LAT,
    parameter int CNT_W = clog2(LAT + 1)
) (
    input  logic                 clk,
    input  logic                 nrst,
    msk_pipe_ctrl_if.slave       bus
);

    logic [LAT-1:0]   vld;
    logic [CNT_W-1:0] cnt;
    logic             flush;
    logic             stall;
    logic             pipe_en;
    logic             adm;
    logic             out_valid;
    logic             out_fire;

`ifdef MSK_PIPE_FLUSH_EN
    assign flush = bus.flush;
`else
    assign flush = 1'b0;
`endif

    // Only a held result freezes the pipe; bubbles keep moving. Flush forces the drain.
    assign stall    = vld[LAT-1] & ~bus.out_ready;
    assign pipe_en  = ~stall | flush;

    // in_ready ignores in_valid so upstream never sees a combinational loop.
    assign bus.in_ready      = nrst & bus.rnd_valid & ~stall & ~flush;
    assign adm               = bus.in_valid & bus.in_ready;
    assign bus.rnd_ready     = adm;
    assign bus.pipe_in_valid = adm;
    assign bus.pipe_en       = pipe_en;

    assign out_valid     = vld[LAT-1] & ~flush;
    assign out_fire      = out_valid & bus.out_ready;
    assign bus.out_valid = out_valid;
    assign bus.busy      = |vld;
    assign bus.inflight  = cnt;

    msk_vld_shreg #(
        .LAT (LAT)
    ) u_vld (
        .clk  (clk),
        .nrst (nrst),
        .en   (pipe_en),
        .clr  (flush),
        .din  (adm),
        .vld  (vld)
    );

    // Tracks popcount(vld) incrementally; simultaneous admit and retire cancel out.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst)
            cnt <= '0;
        else if (flush)
            cnt <= '0;
        else if (adm && !out_fire)
            cnt <= cnt + 1'b1;
        else if (!adm && out_fire)
            cnt <= cnt - 1'b1;
    end

endmodule

// File: doc/msk_pipe_ctrl.md
Name: msk_pipe_ctrl

Overview:
- Flow controller for a fixed-latency masked gadget pipeline: masked S-box or masked-gate chain built from share-wise primitives.
- Accepts operations on a valid/ready handshake and admits one only when fresh randomness is available.
- Drives one global enable to all pipeline share registers, tracks per-stage occupancy, and presents results on a valid/ready output with backpressure.
- Sits between the round/key-schedule sequencer and the masked datapath; it carries no share data itself.

Parameters:
- LAT, 4, pipeline depth in register stages (>=1); admission-to-output latency is LAT cycles when unstalled.
- CNT_W, 3, width of the in-flight counter; must satisfy 2^CNT_W > LAT.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream has an operation whose shares are on the datapath input bus.
- in_ready  out  1  operation admitted this cycle when in_valid is also high.
- rnd_valid  in  1  randomness bus holds fresh, unused bits.
- rnd_ready  out  1  randomness consumed this cycle.
- pipe_en  out  1  clock enable for every gadget share register.
- pipe_in_valid  out  1  stage-0 capture qualifier; high in the same cycle as the admission handshake.
- out_valid  out  1  last pipeline stage holds a valid result.
- out_ready  in  1  downstream accepts the result.
- busy  out  1  at least one stage is occupied.
- inflight  out  CNT_W  number of occupied stages.

Behaviour:
- Occupancy state: vld[LAT-1:0] shift register, one bit per stage; vld[LAT-1] is the output stage.
- Reset (nrst low, asynchronous): vld=0, inflight=0. Hence out_valid=0, busy=0, pipe_en=1, in_ready=0, rnd_ready=0.
- stall = vld[LAT-1] & ~out_ready. pipe_en = ~stall.
- Bubbles advance freely; the whole pipeline freezes only when the output is held.
- adm = in_valid & rnd_valid & pipe_en.
- in_ready = rnd_valid & pipe_en. It does not depend on in_valid, so there is no combinational loop with upstream.
- rnd_ready = adm. Randomness is consumed only on admission, never on bubbles.
- pipe_in_valid = adm.
- On a pipe_en cycle: vld <= {vld[LAT-2:0], adm}. For LAT=1: vld <= adm.
- On a stall cycle: vld holds and no admission occurs.
- out_valid = vld[LAT-1]. Output handshake fires on out_valid & out_ready.
- Simultaneous output handshake and admission in the same cycle is legal; full throughput is 1 op/cycle.
- inflight update:
  - +1 on admission without output fire.
  - −1 on output fire without admission.
  - unchanged when both or neither occur.
  - Always equals popcount(vld). inflight == LAT only when all stages are full.
- busy = |vld.
- rnd_valid low with in_valid high: no admission; a bubble enters if pipe_en is high.
- out_ready dropping while out_valid is high: the result is held stable (pipe_en low) until accepted. out_valid never deasserts without a handshake.
- Reset mid-operation: all in-flight ops are discarded, with no output handshake. The gadget data registers are not cleared by this block.
- All outputs except inflight are combinational from vld and the inputs; inflight is registered.

Optional Feature:
- Macro: MSK_PIPE_FLUSH_EN.
- With the macro defined:
  - Extra input port flush (1 bit).
  - A flush cycle synchronously clears vld and inflight on the next edge, overriding admission and shifting.
  - in_ready and rnd_ready are forced low during flush, so no randomness is wasted.
  - out_valid is forced low during flush.
  - pipe_en is held at 1 during flush so the datapath drains.
- Without the macro: no flush port; the only way to clear state is nrst.

Decomposition:
- Shared package msk_pkg: default LAT constants per gadget family (e.g. MSK_SBOX_LAT=4, MSK_AND_LAT=1) and the CNT_W derivation function clog2(LAT+1).
- One sub-module, msk_vld_shreg: a LAT-deep enable-gated occupancy shift register with async active-low reset and optional sync clear.
- Counter, handshake logic and stall logic stay in msk_pipe_ctrl.

Test Plan:
- Reset: hold nrst=0 with in_valid=1, rnd_valid=1 → out_valid=0, busy=0, inflight=0, pipe_en=1, in_ready=0. Release nrst → first admission on the next edge.
- Streaming with LAT=4, in_valid=rnd_valid=out_ready=1 for 10 cycles → out_valid rises exactly 4 cycles after the first admission, 10 consecutive outputs, inflight saturates at 4, rnd_ready high 10 cycles.
- Randomness starvation: rnd_valid toggling 1,0,1,0 with in_valid=1 → in_ready and rnd_ready follow rnd_valid, bubbles appear at the output in the same pattern, and the output count equals the rnd_valid-high count.
- Backpressure: fill 4 ops, then out_ready=0 for 5 cycles → pipe_en=0, in_ready=0, inflight=4, out_valid held at 1. Raise out_ready → one output per cycle, inflight reaching 0 after 4 cycles if in_valid=0.
- Mid-operation reset: after 2 admissions, pulse nrst low asynchronously between edges → vld, inflight and busy clear immediately, and no out_valid follows.
- MSK_PIPE_FLUSH_EN: 3 ops in flight, assert flush for one cycle with in_valid=rnd_valid=1 → in_ready=0, rnd_ready=0, out_valid=0 that cycle; next cycle inflight=0, and admission resumes the cycle after flush deasserts.
